// File: rtl/ws2812_pixel_rx.sv
// ws2812_pixel_rx
//   UART 8N1 receiver that assembles three consecutive good bytes into one
//   24-bit GRB pixel ({G,R,B}) for a downstream WS2812 encoder. The pixel is
//   held in an output register with a valid/ready handshake. Reception never
//   stalls: a pixel completing while the previous one is still held and not
//   being accepted is dropped and flagged on o_overrun.
//
//   Parameters
//     CLKS_PER_BIT  clk cycles per UART bit (4..65535)
//     TIMEOUT_CLKS  idle cycles after which a partial pixel is discarded
//                   (only used when BYTE_TIMEOUT_EN is defined)
//
//   Optional feature macro: BYTE_TIMEOUT_EN (inter-byte timeout)
//
//   Ports
//     clk            system clock, rising edge
//     rst            asynchronous active-high reset
//     i_rx_serial    UART serial line, idle high, LSB first, asynchronous
//     o_pixel_data   assembled pixel {G,R,B}
//     o_pixel_valid  o_pixel_data holds an unconsumed pixel
//     i_pixel_ready  downstream accepts when high together with o_pixel_valid
//     o_frame_err    one-cycle pulse on a bad stop bit
//     o_overrun      one-cycle pulse when a completed pixel is dropped
module ws2812_pixel_rx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned TIMEOUT_CLKS = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_rx_serial,
  output logic [23:0] o_pixel_data,
  output logic        o_pixel_valid,
  input  logic        i_pixel_ready,
  output logic        o_frame_err,
  output logic        o_overrun
);

  if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 65535) begin : g_bad_clks_per_bit
    $error("CLKS_PER_BIT out of range 4..65535");
  end
  if (TIMEOUT_CLKS < 1) begin : g_bad_timeout
    $error("TIMEOUT_CLKS must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'((CLKS_PER_BIT / 2) - 1);

  logic        rx_meta_q,   rx_meta_d;
  logic        rx_sync_q,   rx_sync_d;
  state_t      state_q,     state_d;
  logic [15:0] cnt_q,       cnt_d;
  logic [2:0]  bit_q,       bit_d;
  logic [7:0]  shift_q,     shift_d;
  logic [1:0]  byte_idx_q,  byte_idx_d;
  logic [7:0]  g_q,         g_d;
  logic [7:0]  r_q,         r_d;
  logic [23:0] pixel_q,     pixel_d;
  logic        valid_q,     valid_d;
  logic        frame_err_q, frame_err_d;
  logic        overrun_q,   overrun_d;
  logic        pixel_done;
`ifdef BYTE_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CLKS - 1);
  logic [31:0] to_cnt_q,    to_cnt_d;
`endif

  always_comb begin
    rx_meta_d   = i_rx_serial;
    rx_sync_d   = rx_meta_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    byte_idx_d  = byte_idx_q;
    g_d         = g_q;
    r_d         = r_q;
    pixel_d     = pixel_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    pixel_done  = 1'b0;

    if (valid_q && i_pixel_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!rx_sync_q) begin
          state_d = START;
        end
      end
      START: begin
        // Mid-start-bit recheck: a line that is high again was a glitch.
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = rx_sync_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rx_sync_q) begin
            case (byte_idx_q)
              2'd0: begin
                g_d        = shift_q;
                byte_idx_d = 2'd1;
              end
              2'd1: begin
                r_d        = shift_q;
                byte_idx_d = 2'd2;
              end
              default: begin
                pixel_done = 1'b1;
                byte_idx_d = 2'd0;
              end
            endcase
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A pixel accepted this cycle frees the register for the new one, so
    // valid stays high with no overrun.
    if (pixel_done) begin
      if (!valid_q || i_pixel_ready) begin
        pixel_d = {g_q, r_q, shift_q};
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end

`ifdef BYTE_TIMEOUT_EN
    to_cnt_d = '0;
    if (state_q == IDLE && rx_sync_q && byte_idx_q != 2'd0) begin
      if (to_cnt_q == TO_LAST) begin
        byte_idx_d = 2'd0;
      end else begin
        to_cnt_d = to_cnt_q + 32'd1;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      byte_idx_q  <= '0;
      g_q         <= '0;
      r_q         <= '0;
      pixel_q     <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef BYTE_TIMEOUT_EN
      to_cnt_q    <= '0;
`endif
    end else begin
      rx_meta_q   <= rx_meta_d;
      rx_sync_q   <= rx_sync_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      byte_idx_q  <= byte_idx_d;
      g_q         <= g_d;
      r_q         <= r_d;
      pixel_q     <= pixel_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef BYTE_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
`endif
    end
  end

  assign o_pixel_data  = pixel_q;
  assign o_pixel_valid = valid_q;
  assign o_frame_err   = frame_err_q;
  assign o_overrun     = overrun_q;

endmodule
